// File: rtl/z80_reg_block_if.sv
// Control bundle for the Z80 register block: register selects, exchange
// strobes, byte enables, bus gates and switch #4 direction.
interface z80_reg_block_if;
    logic [1:0] ctl_reg_gp_sel;
    logic [1:0] ctl_reg_gp_hilo;
    logic       ctl_reg_gp_we;
    logic [1:0] ctl_reg_sys_hilo;
    logic       ctl_reg_sys_we_hi;
    logic       ctl_reg_sys_we_lo;
    logic       ctl_reg_sys_we;
    logic       ctl_reg_sel_pc;
    logic       ctl_reg_sel_ir;
    logic       ctl_reg_sel_wz;
    logic       ctl_reg_not_pc;
    logic       ctl_reg_use_sp;
    logic       use_ixiy;
    logic       use_ix;
    logic       ctl_reg_exx;
    logic       ctl_reg_ex_af;
    logic       ctl_reg_ex_de_hl;
    logic       ctl_reg_in_hi;
    logic       ctl_reg_in_lo;
    logic       ctl_reg_out_hi;
    logic       ctl_reg_out_lo;
    logic       ctl_sw_4d;
    logic       ctl_sw_4u;

    modport master (
        output ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we,
        output ctl_reg_sys_hilo, ctl_reg_sys_we_hi, ctl_reg_sys_we_lo, ctl_reg_sys_we,
        output ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_wz, ctl_reg_not_pc,
        output ctl_reg_use_sp, use_ixiy, use_ix,
        output ctl_reg_exx, ctl_reg_ex_af, ctl_reg_ex_de_hl,
        output ctl_reg_in_hi, ctl_reg_in_lo, ctl_reg_out_hi, ctl_reg_out_lo,
        output ctl_sw_4d, ctl_sw_4u
    );

    modport slave (
        input ctl_reg_gp_sel, ctl_reg_gp_hilo, ctl_reg_gp_we,
        input ctl_reg_sys_hilo, ctl_reg_sys_we_hi, ctl_reg_sys_we_lo, ctl_reg_sys_we,
        input ctl_reg_sel_pc, ctl_reg_sel_ir, ctl_reg_sel_wz, ctl_reg_not_pc,
        input ctl_reg_use_sp, use_ixiy, use_ix,
        input ctl_reg_exx, ctl_reg_ex_af, ctl_reg_ex_de_hl,
        input ctl_reg_in_hi, ctl_reg_in_lo, ctl_reg_out_hi, ctl_reg_out_lo,
        input ctl_sw_4d, ctl_sw_4u
    );
endinterface

// File: rtl/z80_reg_block.sv
// Z80 register control and register file: GP banks on the data-side buses,
// system registers on the address-side buses, joined by bus switch #4.
module z80_reg_block (
    input  logic              clk,
    input  logic              nreset,
    z80_reg_block_if.slave    ctl,
    inout  wire  [7:0]        db_hi_ds,
    inout  wire  [7:0]        db_lo_ds,
    inout  wire  [7:0]        db_hi_as,
    inout  wire  [7:0]        db_lo_as
);

    logic        bank_af;
    logic        bank_exx;
    logic [1:0]  swap_dehl;
    logic [15:0] gp_reg [8];
    logic [15:0] reg_ix, reg_iy, reg_sp, reg_wz, reg_pc, reg_ir;

    logic        hl_slot, gp_is_ix, gp_is_iy, gp_is_sp, gp_to_as;
    logic [1:0]  pair_eff;
    logic [2:0]  gp_idx;
    logic [15:0] gp_rd;

    logic        sel_pc_eff, sel_ir_eff, sel_wz_eff, sys_any;
    logic [15:0] as_rd;
    logic        we_hi, we_lo;
    logic        gp_wr_hi, gp_wr_lo, sys_wr_hi, sys_wr_lo;
    logic        ds_drv_hi, ds_drv_lo, as_drv_hi, as_drv_lo;
    logic        sw_down, sw_up;

    // GP decode: index is {bank, pair}; DE/HL swap flips the pair's low bit.
    always_comb begin
        hl_slot  = (ctl.ctl_reg_gp_sel == 2'b11);
        gp_is_sp = hl_slot & ctl.ctl_reg_use_sp;
        gp_is_ix = hl_slot & ~ctl.ctl_reg_use_sp & ctl.use_ixiy & ctl.use_ix;
        gp_is_iy = hl_slot & ~ctl.ctl_reg_use_sp & ctl.use_ixiy & ~ctl.use_ix;
        gp_to_as = gp_is_sp | gp_is_ix | gp_is_iy;
        pair_eff = ctl.ctl_reg_gp_sel;
        if (swap_dehl[bank_exx] && ctl.ctl_reg_gp_sel[1])
            pair_eff = {1'b1, ~ctl.ctl_reg_gp_sel[0]};
        gp_idx = {(ctl.ctl_reg_gp_sel == 2'b00) ? bank_af : bank_exx, pair_eff};
        gp_rd  = gp_reg[gp_idx];
    end

    always_comb begin
        sel_pc_eff = ctl.ctl_reg_sel_pc & ~ctl.ctl_reg_not_pc;
        sel_ir_eff = ~sel_pc_eff & ctl.ctl_reg_sel_ir;
        sel_wz_eff = ~sel_pc_eff & ~ctl.ctl_reg_sel_ir & ctl.ctl_reg_sel_wz;
        sys_any    = sel_pc_eff | sel_ir_eff | sel_wz_eff;

        if (gp_is_ix)        as_rd = reg_ix;
        else if (gp_is_iy)   as_rd = reg_iy;
        else if (gp_is_sp)   as_rd = reg_sp;
        else if (sel_pc_eff) as_rd = reg_pc;
        else if (sel_ir_eff) as_rd = reg_ir;
        else                 as_rd = reg_wz;

        we_hi     = ctl.ctl_reg_sys_we_hi | (ctl.ctl_reg_sys_we & ctl.ctl_reg_sys_hilo[1]);
        we_lo     = ctl.ctl_reg_sys_we_lo | (ctl.ctl_reg_sys_we & ctl.ctl_reg_sys_hilo[0]);
        gp_wr_hi  = ctl.ctl_reg_gp_we & ctl.ctl_reg_in_hi & ctl.ctl_reg_gp_hilo[1];
        gp_wr_lo  = ctl.ctl_reg_gp_we & ctl.ctl_reg_in_lo & ctl.ctl_reg_gp_hilo[0];
        sys_wr_hi = we_hi & ctl.ctl_reg_in_hi;
        sys_wr_lo = we_lo & ctl.ctl_reg_in_lo;

        ds_drv_hi = ctl.ctl_reg_out_hi & ctl.ctl_reg_gp_hilo[1] & ~gp_to_as;
        ds_drv_lo = ctl.ctl_reg_out_lo & ctl.ctl_reg_gp_hilo[0] & ~gp_to_as;
        as_drv_hi = ctl.ctl_reg_out_hi &
                    (gp_to_as ? ctl.ctl_reg_gp_hilo[1] : (sys_any & ctl.ctl_reg_sys_hilo[1]));
        as_drv_lo = ctl.ctl_reg_out_lo &
                    (gp_to_as ? ctl.ctl_reg_gp_hilo[0] : (sys_any & ctl.ctl_reg_sys_hilo[0]));

        sw_down = ctl.ctl_sw_4d & ~ctl.ctl_sw_4u;
        sw_up   = ctl.ctl_sw_4u & ~ctl.ctl_sw_4d;
    end

    // Upward coupling carries this block's own as-side read data; the downward
    // path forwards the resolved ds net so ds-sourced system writes land this edge.
    assign db_hi_ds = ds_drv_hi              ? gp_rd[15:8] :
                      (sw_up && as_drv_hi)   ? as_rd[15:8] : 8'bz;
    assign db_lo_ds = ds_drv_lo              ? gp_rd[7:0]  :
                      (sw_up && as_drv_lo)   ? as_rd[7:0]  : 8'bz;
    assign db_hi_as = as_drv_hi ? as_rd[15:8] : sw_down ? db_hi_ds : 8'bz;
    assign db_lo_as = as_drv_lo ? as_rd[7:0]  : sw_down ? db_lo_ds : 8'bz;

    always_ff @(posedge clk) begin
        if (nreset) begin
            reg_pc    <= 16'h0000;
            reg_ir    <= 16'h0000;
            bank_af   <= 1'b0;
            bank_exx  <= 1'b0;
            swap_dehl <= 2'b00;
        end else begin
            if (ctl.ctl_reg_ex_af)    bank_af  <= ~bank_af;
            if (ctl.ctl_reg_exx)      bank_exx <= ~bank_exx;
            if (ctl.ctl_reg_ex_de_hl) swap_dehl[bank_exx] <= ~swap_dehl[bank_exx];

            if (gp_wr_hi && !gp_to_as) gp_reg[gp_idx][15:8] <= db_hi_ds;
            if (gp_wr_lo && !gp_to_as) gp_reg[gp_idx][7:0]  <= db_lo_ds;

            if (gp_wr_hi && gp_is_ix) reg_ix[15:8] <= db_hi_as;
            if (gp_wr_lo && gp_is_ix) reg_ix[7:0]  <= db_lo_as;
            if (gp_wr_hi && gp_is_iy) reg_iy[15:8] <= db_hi_as;
            if (gp_wr_lo && gp_is_iy) reg_iy[7:0]  <= db_lo_as;
            if (gp_wr_hi && gp_is_sp) reg_sp[15:8] <= db_hi_as;
            if (gp_wr_lo && gp_is_sp) reg_sp[7:0]  <= db_lo_as;

            if (sys_wr_hi && sel_pc_eff) reg_pc[15:8] <= db_hi_as;
            if (sys_wr_lo && sel_pc_eff) reg_pc[7:0]  <= db_lo_as;
            if (sys_wr_hi && sel_ir_eff) reg_ir[15:8] <= db_hi_as;
            if (sys_wr_lo && sel_ir_eff) reg_ir[7:0]  <= db_lo_as;
            if (sys_wr_hi && sel_wz_eff) reg_wz[15:8] <= db_hi_as;
            if (sys_wr_lo && sel_wz_eff) reg_wz[7:0]  <= db_lo_as;
        end
    end

endmodule

// File: tb/tb_z80_reg_block.sv
// Directed bench for z80_reg_block: expected read values are queued as each
// read is set up and checked against the buses on the following falling edge.
module tb_z80_reg_block;

    logic clk;
    logic nreset;
    wire [7:0] db_hi_ds, db_lo_ds, db_hi_as, db_lo_as;

    logic        tb_ds_oe, tb_as_oe;
    logic [15:0] tb_ds_val, tb_as_val;

    z80_reg_block_if ctl_if ();

    z80_reg_block dut (
        .clk      (clk),
        .nreset   (nreset),
        .ctl      (ctl_if.slave),
        .db_hi_ds (db_hi_ds),
        .db_lo_ds (db_lo_ds),
        .db_hi_as (db_hi_as),
        .db_lo_as (db_lo_as)
    );

    assign db_hi_ds = tb_ds_oe ? tb_ds_val[15:8] : 8'bz;
    assign db_lo_ds = tb_ds_oe ? tb_ds_val[7:0]  : 8'bz;
    assign db_hi_as = tb_as_oe ? tb_as_val[15:8] : 8'bz;
    assign db_lo_as = tb_as_oe ? tb_as_val[7:0]  : 8'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          side;   // 0 = ds, 1 = as
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam bit DS = 1'b0;
    localparam bit AS = 1'b1;

    task automatic clr();
        ctl_if.ctl_reg_gp_sel    = 2'b00;
        ctl_if.ctl_reg_gp_hilo   = 2'b00;
        ctl_if.ctl_reg_gp_we     = 1'b0;
        ctl_if.ctl_reg_sys_hilo  = 2'b00;
        ctl_if.ctl_reg_sys_we_hi = 1'b0;
        ctl_if.ctl_reg_sys_we_lo = 1'b0;
        ctl_if.ctl_reg_sys_we    = 1'b0;
        ctl_if.ctl_reg_sel_pc    = 1'b0;
        ctl_if.ctl_reg_sel_ir    = 1'b0;
        ctl_if.ctl_reg_sel_wz    = 1'b0;
        ctl_if.ctl_reg_not_pc    = 1'b0;
        ctl_if.ctl_reg_use_sp    = 1'b0;
        ctl_if.use_ixiy          = 1'b0;
        ctl_if.use_ix            = 1'b0;
        ctl_if.ctl_reg_exx       = 1'b0;
        ctl_if.ctl_reg_ex_af     = 1'b0;
        ctl_if.ctl_reg_ex_de_hl  = 1'b0;
        ctl_if.ctl_reg_in_hi     = 1'b0;
        ctl_if.ctl_reg_in_lo     = 1'b0;
        ctl_if.ctl_reg_out_hi    = 1'b0;
        ctl_if.ctl_reg_out_lo    = 1'b0;
        ctl_if.ctl_sw_4d         = 1'b0;
        ctl_if.ctl_sw_4u         = 1'b0;
        tb_ds_oe  = 1'b0;
        tb_as_oe  = 1'b0;
        tb_ds_val = 16'h0000;
        tb_as_val = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic push_exp(input string tag, input bit side, input logic [15:0] exp);
        exp_t e;
        e.tag  = tag;
        e.side = side;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [15:0] obs;
        e   = sb.pop_front();
        obs = e.side ? {db_hi_as, db_lo_as} : {db_hi_ds, db_lo_ds};
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    // sel: 0 = PC, 1 = IR, 2 = WZ
    task automatic sys_write(input int sel, input logic [15:0] data);
        ctl_if.ctl_sw_4d         = 1'b1;
        ctl_if.ctl_reg_in_hi     = 1'b1;
        ctl_if.ctl_reg_in_lo     = 1'b1;
        ctl_if.ctl_reg_sys_we_hi = 1'b1;
        ctl_if.ctl_reg_sys_we_lo = 1'b1;
        ctl_if.ctl_reg_sys_hilo  = 2'b11;
        ctl_if.ctl_reg_sel_pc    = (sel == 0);
        ctl_if.ctl_reg_sel_ir    = (sel == 1);
        ctl_if.ctl_reg_sel_wz    = (sel == 2);
        tb_ds_val = data;
        tb_ds_oe  = 1'b1;
        step();
    endtask

    task automatic sys_read(input string tag, input int sel, input bit via_ds,
                            input logic [15:0] exp);
        ctl_if.ctl_reg_out_hi   = 1'b1;
        ctl_if.ctl_reg_out_lo   = 1'b1;
        ctl_if.ctl_reg_sys_hilo = 2'b11;
        ctl_if.ctl_reg_sel_pc   = (sel == 0);
        ctl_if.ctl_reg_sel_ir   = (sel == 1);
        ctl_if.ctl_reg_sel_wz   = (sel == 2);
        ctl_if.ctl_sw_4u        = via_ds;
        push_exp(tag, via_ds ? DS : AS, exp);
        @(negedge clk);
        check_out();
        step();
    endtask

    // The same data goes on both buses; the block must take it from the right side.
    task automatic gp_write(input logic [1:0] sel, input logic [1:0] hilo, input bit ixiy,
                            input bit ix, input bit sp, input logic [15:0] data);
        ctl_if.ctl_reg_gp_sel  = sel;
        ctl_if.ctl_reg_gp_hilo = hilo;
        ctl_if.ctl_reg_gp_we   = 1'b1;
        ctl_if.ctl_reg_in_hi   = 1'b1;
        ctl_if.ctl_reg_in_lo   = 1'b1;
        ctl_if.use_ixiy        = ixiy;
        ctl_if.use_ix          = ix;
        ctl_if.ctl_reg_use_sp  = sp;
        tb_ds_val = data;
        tb_as_val = data;
        tb_ds_oe  = 1'b1;
        tb_as_oe  = 1'b1;
        step();
    endtask

    task automatic gp_read(input string tag, input logic [1:0] sel, input bit ixiy,
                           input bit ix, input bit sp, input bit side, input logic [15:0] exp);
        ctl_if.ctl_reg_gp_sel  = sel;
        ctl_if.ctl_reg_gp_hilo = 2'b11;
        ctl_if.ctl_reg_out_hi  = 1'b1;
        ctl_if.ctl_reg_out_lo  = 1'b1;
        ctl_if.use_ixiy        = ixiy;
        ctl_if.use_ix          = ix;
        ctl_if.ctl_reg_use_sp  = sp;
        push_exp(tag, side, exp);
        @(negedge clk);
        check_out();
        step();
    endtask

    task automatic strobe(input bit ex_af, input bit exx, input bit ex_de_hl);
        ctl_if.ctl_reg_ex_af    = ex_af;
        ctl_if.ctl_reg_exx      = exx;
        ctl_if.ctl_reg_ex_de_hl = ex_de_hl;
        step();
    endtask

    initial begin
        clr();
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b0;

        sys_read("reset_pc", 0, 1'b0, 16'h0000);
        sys_read("reset_ir", 1, 1'b0, 16'h0000);

        sys_write(2, 16'h8141);
        sys_write(0, 16'h8242);
        sys_write(1, 16'h8343);
        sys_read("sys_wz", 2, 1'b1, 16'h8141);
        sys_read("sys_pc", 0, 1'b1, 16'h8242);
        sys_read("sys_ir", 1, 1'b1, 16'h8343);

        gp_write(2'b00, 2'b11, 0, 0, 0, 16'hAA55);
        gp_write(2'b01, 2'b11, 0, 0, 0, 16'hAB56);
        gp_write(2'b10, 2'b11, 0, 0, 0, 16'hAC57);
        gp_write(2'b11, 2'b11, 0, 0, 0, 16'hAD58);
        gp_read("gp_af", 2'b00, 0, 0, 0, DS, 16'hAA55);
        gp_read("gp_bc", 2'b01, 0, 0, 0, DS, 16'hAB56);
        gp_read("gp_de", 2'b10, 0, 0, 0, DS, 16'hAC57);
        gp_read("gp_hl", 2'b11, 0, 0, 0, DS, 16'hAD58);

        gp_write(2'b11, 2'b11, 1, 1, 0, 16'h1111);
        gp_write(2'b11, 2'b11, 1, 0, 0, 16'h2222);
        gp_write(2'b11, 2'b11, 1, 1, 1, 16'h3333);
        gp_read("ix", 2'b11, 1, 1, 0, AS, 16'h1111);
        gp_read("iy", 2'b11, 1, 0, 0, AS, 16'h2222);
        gp_read("sp", 2'b11, 0, 0, 1, AS, 16'h3333);
        gp_read("hl_kept", 2'b11, 0, 0, 0, DS, 16'hAD58);

        gp_write(2'b00, 2'b10, 0, 0, 0, 16'hFF00);
        gp_read("af_hi_only", 2'b00, 0, 0, 0, DS, 16'hFF55);

        // not_pc: the block must leave both buses alone, so the bench's own drive survives.
        ctl_if.ctl_reg_out_hi   = 1'b1;
        ctl_if.ctl_reg_out_lo   = 1'b1;
        ctl_if.ctl_reg_sys_hilo = 2'b11;
        ctl_if.ctl_reg_sel_pc   = 1'b1;
        ctl_if.ctl_reg_not_pc   = 1'b1;
        tb_as_val = 16'h5AA5;
        tb_ds_val = 16'hA55A;
        tb_as_oe  = 1'b1;
        tb_ds_oe  = 1'b1;
        push_exp("not_pc_as_float", AS, 16'h5AA5);
        push_exp("not_pc_ds_float", DS, 16'hA55A);
        @(negedge clk);
        check_out();
        check_out();
        step();

        // Both switch directions at once: switch open, PC still on as, ds left to the bench.
        ctl_if.ctl_reg_out_hi   = 1'b1;
        ctl_if.ctl_reg_out_lo   = 1'b1;
        ctl_if.ctl_reg_sys_hilo = 2'b11;
        ctl_if.ctl_reg_sel_pc   = 1'b1;
        ctl_if.ctl_sw_4d        = 1'b1;
        ctl_if.ctl_sw_4u        = 1'b1;
        tb_ds_val = 16'h3CC3;
        tb_ds_oe  = 1'b1;
        push_exp("sw_open_as_pc", AS, 16'h8242);
        push_exp("sw_open_ds", DS, 16'h3CC3);
        @(negedge clk);
        check_out();
        check_out();
        step();

        gp_write(2'b01, 2'b11, 0, 0, 0, 16'h1234);
        strobe(0, 1, 0);
        gp_write(2'b01, 2'b11, 0, 0, 0, 16'h5678);
        gp_read("bc_alt", 2'b01, 0, 0, 0, DS, 16'h5678);
        strobe(0, 1, 0);
        gp_read("bc_after_exx", 2'b01, 0, 0, 0, DS, 16'h1234);
        strobe(0, 0, 1);
        gp_read("de_swapped", 2'b10, 0, 0, 0, DS, 16'hAD58);
        gp_read("hl_swapped", 2'b11, 0, 0, 0, DS, 16'hAC57);

        strobe(1, 1, 1);
        sys_read("pc_pre_reset", 0, 1'b0, 16'h8242);

        // Reset cycle with a competing WZ write and AF exchange; reset must win.
        ctl_if.ctl_sw_4d         = 1'b1;
        ctl_if.ctl_reg_in_hi     = 1'b1;
        ctl_if.ctl_reg_in_lo     = 1'b1;
        ctl_if.ctl_reg_sys_we_hi = 1'b1;
        ctl_if.ctl_reg_sys_we_lo = 1'b1;
        ctl_if.ctl_reg_sys_hilo  = 2'b11;
        ctl_if.ctl_reg_sel_wz    = 1'b1;
        ctl_if.ctl_reg_ex_af     = 1'b1;
        tb_ds_val = 16'hDEAD;
        tb_ds_oe  = 1'b1;
        nreset    = 1'b1;
        step();
        nreset = 1'b0;

        sys_read("rst_pc", 0, 1'b0, 16'h0000);
        sys_read("rst_ir", 1, 1'b0, 16'h0000);
        sys_read("rst_wz_kept", 2, 1'b0, 16'h8141);
        gp_read("rst_af_primary", 2'b00, 0, 0, 0, DS, 16'hFF55);
        gp_read("rst_bc_primary", 2'b01, 0, 0, 0, DS, 16'h1234);
        gp_read("rst_de_unswapped", 2'b10, 0, 0, 0, DS, 16'hAC57);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
